// File: rtl/booth_mac_accum.sv
// rtl/booth_mac_accum.sv - saturating frame accumulator behind the Booth radix-8 multiplier
module booth_mac_accum #(
  parameter int ACC_W = 24,
  parameter int LAT   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tag_v,
  input  logic [1:0]       tag_sm,
  input  logic             tag_last,
  input  logic             mul_v,
  input  logic [15:0]      mul_p,
  input  logic             clr,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic [7:0]       res_count,
  output logic             res_sat,
  output logic             err_drop,
  output logic             err_align
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Side-band delay line: {v, sm[1:0], last}, one entry per multiplier stage
  logic [3:0] dl [LAT];

  logic       dv;
  logic [1:0] dsm;
  logic       dlast;

  // Always shifts; the multiplier never stalls so neither does its shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) dl[i] <= 4'd0;
    end else begin
      dl[0] <= {tag_v, tag_sm, tag_last};
      for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
    end
  end

  assign dv    = dl[LAT-1][3];
  assign dsm   = dl[LAT-1][2:1];
  assign dlast = dl[LAT-1][0];

  // Running frame state
  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic             fsat;

  logic             consume;
  logic [ACC_W-1:0] ext;
  logic [ACC_W:0]   sum_w;
  logic             ovf;
  logic [ACC_W-1:0] clamped;
  logic [7:0]       cnt_next;
  logic             sat_next;

  assign consume  = mul_v && dv;
  // Any signed operand makes the product signed; only 00 is a pure unsigned product
  assign ext      = (dsm != 2'b00) ? {{(ACC_W-16){mul_p[15]}}, mul_p}
                                   : {{(ACC_W-16){1'b0}}, mul_p};
  // One guard bit: overflow shows up as the top two bits disagreeing
  assign sum_w    = {acc[ACC_W-1], acc} + {ext[ACC_W-1], ext};
  assign ovf      = sum_w[ACC_W] ^ sum_w[ACC_W-1];
  assign clamped  = ovf ? (sum_w[ACC_W] ? ACC_MIN : ACC_MAX) : sum_w[ACC_W-1:0];
  assign cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign sat_next = fsat | ovf;

  // FIFO handshake
  logic [1:0] occ;
  logic       pop;
  logic       push_req;
  logic       push;
  logic       drop;

  assign pop      = res_valid && res_ready;
  assign push_req = consume && dlast;
  // A pop in the same cycle frees the slot, so a full buffer still accepts
  assign push     = push_req && ((occ != 2'd2) || pop);
  assign drop     = push_req && (occ == 2'd2) && !pop;

  // Accumulate; a frame-last product restarts the frame in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      cnt  <= 8'd0;
      fsat <= 1'b0;
    end else if (clr || (consume && dlast)) begin
      acc  <= '0;
      cnt  <= 8'd0;
      fsat <= 1'b0;
    end else if (consume) begin
      acc  <= clamped;
      cnt  <= cnt_next;
      fsat <= sat_next;
    end
  end

  // Sticky error flags; clr takes priority over a same-cycle event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_align <= 1'b0;
      err_drop  <= 1'b0;
    end else if (clr) begin
      err_align <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      if (mul_v != dv) err_align <= 1'b1;
      if (drop)        err_drop  <= 1'b1;
    end
  end

  // Two-entry result buffer
  logic [ACC_W-1:0] mem_data [2];
  logic [7:0]       mem_cnt  [2];
  logic             mem_sat  [2];
  logic             wr_ptr;
  logic             rd_ptr;

  // Storage and pointers; entries are cleared on reset so res_data reads 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_cnt[i]  <= 8'd0;
        mem_sat[i]  <= 1'b0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= clamped;
        mem_cnt[wr_ptr]  <= cnt_next;
        mem_sat[wr_ptr]  <= sat_next;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign res_valid = (occ != 2'd0);
  assign res_data  = mem_data[rd_ptr];
  assign res_count = mem_cnt[rd_ptr];
  assign res_sat   = mem_sat[rd_ptr];

endmodule
